brick_mem_ctrl: RTL and testbench
=================================

BRICK_MEM_CTRL -- requirements
Module: brick_mem_ctrl

Interface
REQ-001 SHALL have parameter NUM_BRICKS, default 128, brick count (16 across x 8 down).
REQ-002 SHALL have parameter IDX_W, default 7, brick index width (clog2 NUM_BRICKS).
REQ-003 SHALL have port clk, input, 1, pixel clock; the block's one clock.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port rd_req, input, 1, video-scan read request.
REQ-006 SHALL have port rd_index, input, IDX_W, brick to read.
REQ-007 SHALL have port rd_data, output, 1, 1 = brick present, registered.
REQ-008 SHALL have port hit_req, input, 1, collision logic requests removal of a brick.
REQ-009 SHALL have port hit_index, input, IDX_W, brick hit.
REQ-010 SHALL have port hit_ack, output, 1, one-cycle pulse: hit accepted.
REQ-011 SHALL have port hit_scored, output, 1, one-cycle pulse: a present brick was removed (drives score increment).
REQ-012 SHALL have port clear_req, input, 1, refill all bricks (new level/game).
REQ-013 SHALL have port busy, output, 1, high in FILL or while a hit is pending.
REQ-014 SHALL have port bricks_left, output, IDX_W+1, count of present bricks.
REQ-015 SHALL have port level_done, output, 1, one-cycle pulse when bricks_left reaches 0 via a hit.

Function
REQ-016 SHALL store NUM_BRICKS x 1-bit in a single-port array (one access per clk edge).
REQ-017 SHALL implement states FILL, IDLE, HIT_RD, HIT_WR.
REQ-018 FILL: write 1 to entry fill_idx each edge, fill_idx 0..NUM_BRICKS-1; after last write -> IDLE, bricks_left <= NUM_BRICKS (same edge).
REQ-019 During FILL, rd_req SHALL be ignored; rd_data SHALL be 0; hit_req SHALL not be acknowledged.
REQ-020 In IDLE, HIT_RD and HIT_WR, rd_req SHALL have absolute priority: edge with rd_req=1 reads rd_index; rd_data valid the following cycle; otherwise rd_data holds.
REQ-021 IDLE with hit_req=1 at edge N: latch hit_index, hit_ack=1 during cycle N+1, -> HIT_RD.
REQ-022 HIT_RD: at first edge with rd_req=0, read latched entry into hit_bit; -> HIT_WR; stalls while rd_req=1.
REQ-023 HIT_WR: at first edge with rd_req=0, if hit_bit=1 write 0, decrement bricks_left, hit_scored=1 next cycle; -> IDLE. If hit_bit=0, no write, no score.
REQ-024 Unstalled hit latency: accepted edge N, read N+1, write N+2, hit_scored high cycle after N+2.
REQ-025 level_done SHALL pulse in the same cycle as hit_scored when the decrement yields 0.
REQ-026 hit_req while not IDLE SHALL be ignored (requester must hold until hit_ack).
REQ-027 clear_req=1 at any edge SHALL win over all else: pending hit dropped (no hit_scored), fill_idx <= 0, bricks_left <= 0, -> FILL; clear_req during FILL restarts the fill.
REQ-028 level_done SHALL NOT pulse on clear or FILL.
REQ-029 bricks_left SHALL never underflow (decrement only on hit_bit=1).

Reset
REQ-030 Reset asserted SHALL force state FILL, fill_idx=0, bricks_left=0, rd_data=0, hit_ack=0, hit_scored=0, level_done=0, busy=1.
REQ-031 Array contents SHALL NOT be reset; FILL after reset release SHALL initialise them.
REQ-032 Reset asserted mid-FILL or mid-hit SHALL abort the operation with no pulses.

Structure
REQ-033 State encoding, NUM_BRICKS and BRICKS_H/BRICKS_V constants SHALL live in the shared game package.
REQ-034 The 1-bit single-port array SHALL be a sub-module brick_ram (clk, we, addr, wdata, rdata) for iCE40 inference.

Verification
REQ-035 Reset, release, idle 128 cycles -> busy drops at cycle 128, bricks_left=128, rd_req idx 5 -> rd_data=1.
REQ-036 hit_req idx 37, no reads -> hit_ack next cycle, hit_scored 3 cycles after accept, bricks_left=127, read idx 37 -> 0.
REQ-037 Repeat hit idx 37 -> hit_ack, no hit_scored, bricks_left stays 127.
REQ-038 Hit idx 10 with rd_req held high 4 cycles -> hit_scored delayed exactly 4 cycles; all reads return correct data.
REQ-039 Remove all 128 bricks -> level_done single pulse with last hit_scored, bricks_left=0.
REQ-040 clear_req during HIT_RD -> no hit_scored, FILL restarts, bricks_left=128 after 128 cycles.

Source files
------------

// File: rtl/brick_mem_ctrl_pkg.sv
// Shared game constants and controller state encoding for the brick wall.
package brick_mem_ctrl_pkg;

   localparam int BRICKS_H   = 16;
   localparam int BRICKS_V   = 8;
   localparam int NUM_BRICKS = BRICKS_H * BRICKS_V;
   localparam int IDX_W      = $clog2(NUM_BRICKS);

   typedef enum logic [1:0] {
      ST_FILL,
      ST_IDLE,
      ST_HIT_RD,
      ST_HIT_WR
   } state_t;

endpackage

// File: rtl/brick_mem_ctrl_if.sv
// Video-scan read port and collision hit port of the brick memory controller.
interface brick_mem_ctrl_if #(
   parameter int IDX_W = 7
);

   logic             rd_req;
   logic [IDX_W-1:0] rd_index;
   logic             rd_data;
   logic             hit_req;
   logic [IDX_W-1:0] hit_index;
   logic             hit_ack;
   logic             hit_scored;
   logic             clear_req;
   logic             busy;
   logic [IDX_W:0]   bricks_left;
   logic             level_done;

   modport master (
      output rd_req, rd_index, hit_req, hit_index, clear_req,
      input  rd_data, hit_ack, hit_scored, busy, bricks_left, level_done
   );

   modport slave (
      input  rd_req, rd_index, hit_req, hit_index, clear_req,
      output rd_data, hit_ack, hit_scored, busy, bricks_left, level_done
   );

endinterface

// File: rtl/brick_mem_ctrl_ram.sv
// 1-bit wide single-port brick RAM, read-before-write, registered read data.
module brick_ram #(
   parameter int DEPTH = 128,
   parameter int AW    = 7
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic          wdata,
   output logic          rdata
);

   logic r_mem [DEPTH];

   // One access per edge: optional write plus registered read of the same entry.
   // NOTE: the array has no reset; a reset would stop block-RAM inference, and the FILL sweep initialises it.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
      rdata <= r_mem[addr];
   end

endmodule

// File: rtl/brick_mem_ctrl.sv
// Brick presence memory controller: fill sweep, scan reads, collision removals.
module brick_mem_ctrl
   import brick_mem_ctrl_pkg::*;
#(
   parameter int NUM_BRICKS = brick_mem_ctrl_pkg::NUM_BRICKS,
   parameter int IDX_W      = brick_mem_ctrl_pkg::IDX_W
) (
   input  logic              clk,
   input  logic              reset,
   brick_mem_ctrl_if.slave   bus
);

   state_t           r_state, w_state_nxt;
   logic [IDX_W-1:0] r_fill_idx;
   logic [IDX_W-1:0] r_hit_idx;
   logic [IDX_W:0]   r_bricks_left;
   logic             r_hit_ack, r_hit_scored, r_level_done;
   logic             r_rd_valid, r_rd_hold;
   logic             r_hit_rd_valid, r_hit_bit;

   logic             w_we, w_wdata, w_ram_rdata;
   logic [IDX_W-1:0] w_addr;
   logic             w_rd_fire, w_hit_accept, w_hit_read, w_score;
   logic             w_rd_data, w_hit_bit;

   brick_ram #(
      .DEPTH (NUM_BRICKS),
      .AW    (IDX_W)
   ) u_ram (
      .clk   (clk),
      .we    (w_we),
      .addr  (w_addr),
      .wdata (w_wdata),
      .rdata (w_ram_rdata)
   );

   // RAM output is live only the cycle after a read; otherwise the last value is held.
   assign w_rd_data = r_rd_valid ? w_ram_rdata : r_rd_hold;
   // The hit read lands in the first HIT_WR cycle; later (stalled) cycles use the captured copy.
   assign w_hit_bit = r_hit_rd_valid ? w_ram_rdata : r_hit_bit;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and RAM port arbitration; scan reads always win the port.
   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_we         = 1'b0;
      w_wdata      = 1'b0;
      w_addr       = bus.rd_index;
      w_rd_fire    = 1'b0;
      w_hit_accept = 1'b0;
      w_hit_read   = 1'b0;
      w_score      = 1'b0;
      if (bus.clear_req) begin
         w_state_nxt = ST_FILL;
      end else begin
         unique case (r_state)
            ST_FILL: begin
               w_we    = 1'b1;
               w_wdata = 1'b1;
               w_addr  = r_fill_idx;
               if (r_fill_idx == IDX_W'(NUM_BRICKS - 1)) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
               w_rd_fire = bus.rd_req;
               if (bus.hit_req) begin
                  w_hit_accept = 1'b1;
                  w_state_nxt  = ST_HIT_RD;
               end
            end
            ST_HIT_RD: begin
               if (bus.rd_req) begin
                  w_rd_fire = 1'b1;
               end else begin
                  w_addr      = r_hit_idx;
                  w_hit_read  = 1'b1;
                  w_state_nxt = ST_HIT_WR;
               end
            end
            ST_HIT_WR: begin
               if (bus.rd_req) begin
                  w_rd_fire = 1'b1;
               end else begin
                  w_addr      = r_hit_idx;
                  w_we        = w_hit_bit;
                  w_score     = w_hit_bit;
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_FILL;
         endcase
      end
   end

   // Datapath: fill counter, hit latch, brick count, read-data hold and output pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fill_idx     <= '0;
         r_hit_idx      <= '0;
         r_bricks_left  <= '0;
         r_hit_ack      <= 1'b0;
         r_hit_scored   <= 1'b0;
         r_level_done   <= 1'b0;
         r_rd_valid     <= 1'b0;
         r_rd_hold      <= 1'b0;
         r_hit_rd_valid <= 1'b0;
         r_hit_bit      <= 1'b0;
      end else if (bus.clear_req) begin
         r_fill_idx     <= '0;
         r_bricks_left  <= '0;
         r_hit_ack      <= 1'b0;
         r_hit_scored   <= 1'b0;
         r_level_done   <= 1'b0;
         r_rd_valid     <= 1'b0;
         r_rd_hold      <= 1'b0;
         r_hit_rd_valid <= 1'b0;
      end else begin
         r_hit_ack      <= w_hit_accept;
         r_hit_scored   <= w_score;
         r_level_done   <= w_score && (r_bricks_left == (IDX_W+1)'(1));
         r_hit_rd_valid <= w_hit_read;
         r_hit_bit      <= w_hit_bit;
         if (r_state == ST_FILL) begin
            r_fill_idx <= r_fill_idx + 1'b1;
            r_rd_valid <= 1'b0;
            r_rd_hold  <= 1'b0;
            if (r_fill_idx == IDX_W'(NUM_BRICKS - 1)) r_bricks_left <= (IDX_W+1)'(NUM_BRICKS);
         end else begin
            r_rd_valid <= w_rd_fire;
            r_rd_hold  <= w_rd_data;
            if (w_score) r_bricks_left <= r_bricks_left - 1'b1;
         end
         if (w_hit_accept) r_hit_idx <= bus.hit_index;
      end
   end

   assign bus.rd_data     = w_rd_data;
   assign bus.hit_ack     = r_hit_ack;
   assign bus.hit_scored  = r_hit_scored;
   assign bus.level_done  = r_level_done;
   assign bus.bricks_left = r_bricks_left;
   assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_brick_mem_ctrl.sv
// Directed bench for brick_mem_ctrl: fill, reads, hits, stalls, level clear, clear abort.
module tb_brick_mem_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   left;

   brick_mem_ctrl_if #(.IDX_W(7)) bus ();

   brick_mem_ctrl #(.NUM_BRICKS(128), .IDX_W(7)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Full unstalled hit: accept, read, write; checks ack, score and level pulse.
   task automatic do_hit(input logic [6:0] idx, input logic present);
      bus.hit_req   = 1'b1;
      bus.hit_index = idx;
      step();
      bus.hit_req = 1'b0;
      chk("hit_ack", {31'd0, bus.hit_ack}, 32'd1);
      step();
      step();
      if (present) left--;
      chk("hit_scored", {31'd0, bus.hit_scored}, {31'd0, present});
      chk("level_done", {31'd0, bus.level_done}, {31'd0, (present && left == 0)});
      chk("bricks_left", {24'd0, bus.bricks_left}, left);
   endtask

   initial begin
      reset         = 1'b1;
      bus.rd_req    = 1'b0;
      bus.rd_index  = '0;
      bus.hit_req   = 1'b0;
      bus.hit_index = '0;
      bus.clear_req = 1'b0;
      step();
      step();
      chk("rst_busy", {31'd0, bus.busy}, 32'd1);
      chk("rst_bricks", {24'd0, bus.bricks_left}, 32'd0);
      chk("rst_rd_data", {31'd0, bus.rd_data}, 32'd0);
      chk("rst_ack", {31'd0, bus.hit_ack}, 32'd0);
      chk("rst_scored", {31'd0, bus.hit_scored}, 32'd0);
      reset = 1'b0;

      // Fill sweep: 128 edges; requests mid-fill are ignored.
      for (int i = 1; i < 60; i++) step();
      bus.rd_req    = 1'b1;
      bus.rd_index  = 7'd5;
      bus.hit_req   = 1'b1;
      bus.hit_index = 7'd9;
      step();
      bus.rd_req  = 1'b0;
      bus.hit_req = 1'b0;
      chk("fill_rd_data", {31'd0, bus.rd_data}, 32'd0);
      chk("fill_ack", {31'd0, bus.hit_ack}, 32'd0);
      for (int i = 61; i < 128; i++) step();
      chk("fill_busy127", {31'd0, bus.busy}, 32'd1);
      chk("fill_bricks127", {24'd0, bus.bricks_left}, 32'd0);
      step();
      chk("fill_busy128", {31'd0, bus.busy}, 32'd0);
      chk("fill_bricks128", {24'd0, bus.bricks_left}, 32'd128);
      left = 128;

      bus.rd_req   = 1'b1;
      bus.rd_index = 7'd5;
      step();
      bus.rd_req = 1'b0;
      chk("read5", {31'd0, bus.rd_data}, 32'd1);

      // Hit 37 with exact per-cycle latency.
      bus.hit_req   = 1'b1;
      bus.hit_index = 7'd37;
      step();
      bus.hit_req = 1'b0;
      chk("h37_ack", {31'd0, bus.hit_ack}, 32'd1);
      chk("h37_busy", {31'd0, bus.busy}, 32'd1);
      step();
      chk("h37_ack_off", {31'd0, bus.hit_ack}, 32'd0);
      chk("h37_early", {31'd0, bus.hit_scored}, 32'd0);
      step();
      chk("h37_scored", {31'd0, bus.hit_scored}, 32'd1);
      chk("h37_bricks", {24'd0, bus.bricks_left}, 32'd127);
      chk("h37_level", {31'd0, bus.level_done}, 32'd0);
      left = 127;
      step();
      chk("h37_pulse_off", {31'd0, bus.hit_scored}, 32'd0);
      bus.rd_req   = 1'b1;
      bus.rd_index = 7'd37;
      step();
      bus.rd_req = 1'b0;
      chk("read37", {31'd0, bus.rd_data}, 32'd0);

      // Repeat hit on an already-removed brick.
      do_hit(7'd37, 1'b0);

      // Hit 10 stalled by four scan reads.
      bus.hit_req   = 1'b1;
      bus.hit_index = 7'd10;
      step();
      bus.hit_req = 1'b0;
      chk("h10_ack", {31'd0, bus.hit_ack}, 32'd1);
      bus.rd_req   = 1'b1;
      bus.rd_index = 7'd10;
      step();
      chk("stall_rd10", {31'd0, bus.rd_data}, 32'd1);
      chk("stall_sc1", {31'd0, bus.hit_scored}, 32'd0);
      bus.rd_index = 7'd37;
      step();
      chk("stall_rd37", {31'd0, bus.rd_data}, 32'd0);
      bus.rd_index = 7'd5;
      step();
      chk("stall_rd5", {31'd0, bus.rd_data}, 32'd1);
      chk("stall_sc3", {31'd0, bus.hit_scored}, 32'd0);
      bus.rd_index = 7'd10;
      step();
      chk("stall_rd10b", {31'd0, bus.rd_data}, 32'd1);
      bus.rd_req = 1'b0;
      step();
      chk("stall_sc5", {31'd0, bus.hit_scored}, 32'd0);
      chk("stall_hold", {31'd0, bus.rd_data}, 32'd1);
      step();
      chk("h10_scored", {31'd0, bus.hit_scored}, 32'd1);
      chk("h10_bricks", {24'd0, bus.bricks_left}, 32'd126);
      left = 126;
      step();
      bus.rd_req   = 1'b1;
      bus.rd_index = 7'd10;
      step();
      bus.rd_req = 1'b0;
      chk("read10", {31'd0, bus.rd_data}, 32'd0);

      // Clear the remaining 126 bricks; the last one raises level_done.
      for (int i = 0; i < 128; i++) begin
         if (i != 10 && i != 37) do_hit(7'(i), 1'b1);
      end
      step();
      chk("level_single", {31'd0, bus.level_done}, 32'd0);
      chk("empty_bricks", {24'd0, bus.bricks_left}, 32'd0);
      do_hit(7'd0, 1'b0);

      // Refill, then abort a hit in HIT_RD with clear_req.
      bus.clear_req = 1'b1;
      step();
      bus.clear_req = 1'b0;
      chk("clr_busy", {31'd0, bus.busy}, 32'd1);
      for (int i = 0; i < 128; i++) step();
      chk("refill_bricks", {24'd0, bus.bricks_left}, 32'd128);
      bus.hit_req   = 1'b1;
      bus.hit_index = 7'd3;
      step();
      bus.hit_req = 1'b0;
      chk("h3_ack", {31'd0, bus.hit_ack}, 32'd1);
      bus.clear_req = 1'b1;
      step();
      bus.clear_req = 1'b0;
      chk("abort_scored", {31'd0, bus.hit_scored}, 32'd0);
      chk("abort_bricks", {24'd0, bus.bricks_left}, 32'd0);
      chk("abort_level", {31'd0, bus.level_done}, 32'd0);
      step();
      chk("abort_scored2", {31'd0, bus.hit_scored}, 32'd0);
      for (int i = 1; i < 127; i++) step();
      chk("abort_busy127", {31'd0, bus.busy}, 32'd1);
      step();
      chk("abort_busy128", {31'd0, bus.busy}, 32'd0);
      chk("abort_bricks128", {24'd0, bus.bricks_left}, 32'd128);
      bus.rd_req   = 1'b1;
      bus.rd_index = 7'd3;
      step();
      bus.rd_req = 1'b0;
      chk("read3", {31'd0, bus.rd_data}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
